// File: rtl/eth_tx_arb.sv
// Two-source Ethernet TX arbiter (ARP / UDP).
// Round-robin grant, byte forwarding, frame-size abort, IFG timing.
module eth_tx_arb #(
  parameter int IFG_CYCLES = 12,
  parameter int MAX_FRAME  = 1536
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_arp_req,
  input  logic [7:0] i_arp_data,
  input  logic       i_arp_data_vl,
  input  logic       i_arp_last,
  output logic       o_arp_gnt,
  input  logic       i_udp_req,
  input  logic [7:0] i_udp_data,
  input  logic       i_udp_data_vl,
  input  logic       i_udp_last,
  output logic       o_udp_gnt,
  output logic [7:0] o_data,
  output logic       o_data_vl,
  output logic       o_busy,
  output logic       o_abort
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [10:0] LIM  = 11'(MAX_FRAME - 1);
  localparam logic [10:0] GLIM = 11'(IFG_CYCLES - 1);

  state_t      r_state;
  logic        r_arp_gnt;
  logic        r_udp_gnt;
  logic [10:0] r_cnt;
  logic        r_last_udp;
  logic [7:0]  r_data;
  logic        r_data_vl;
  logic        r_abort;

  state_t      w_state_n;
  logic        w_arp_gnt_n;
  logic        w_udp_gnt_n;
  logic [10:0] w_cnt_n;
  logic        w_last_udp_n;
  logic [7:0]  w_data_n;
  logic        w_data_vl_n;
  logic        w_abort_n;

  logic [7:0]  w_sel_data;
  logic        w_sel_vl;
  logic        w_sel_last;
  logic        w_pick_udp;

  assign w_sel_data = r_udp_gnt ? i_udp_data : i_arp_data;
  assign w_sel_vl   = (r_arp_gnt & i_arp_data_vl)
                    | (r_udp_gnt & i_udp_data_vl);
  assign w_sel_last = (r_arp_gnt & i_arp_last)
                    | (r_udp_gnt & i_udp_last);
  // UDP wins only if alone or ARP was served last.
  assign w_pick_udp = i_udp_req & (~i_arp_req | ~r_last_udp);

  // Next-state and next-output logic.
  always_comb begin
    w_state_n    = r_state;
    w_arp_gnt_n  = r_arp_gnt;
    w_udp_gnt_n  = r_udp_gnt;
    w_cnt_n      = r_cnt;
    w_last_udp_n = r_last_udp;
    w_data_n     = r_data;
    w_data_vl_n  = 1'b0;
    w_abort_n    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_arp_req | i_udp_req) begin
          w_state_n    = XFER;
          w_arp_gnt_n  = ~w_pick_udp;
          w_udp_gnt_n  = w_pick_udp;
          w_last_udp_n = w_pick_udp;
          w_cnt_n      = '0;
        end
      end
      XFER: begin
        w_data_vl_n = w_sel_vl;
        if (w_sel_vl) begin
          w_data_n = w_sel_data;
          w_cnt_n  = r_cnt + 11'd1;
          if (w_sel_last || (r_cnt == LIM)) begin
            w_state_n   = GAP;
            w_arp_gnt_n = 1'b0;
            w_udp_gnt_n = 1'b0;
            w_cnt_n     = '0;
            w_abort_n   = ~w_sel_last;
          end
        end
      end
      GAP: begin
        if (r_cnt == GLIM) begin
          w_state_n = IDLE;
          w_cnt_n   = '0;
        end else begin
          w_cnt_n = r_cnt + 11'd1;
        end
      end
      default: begin
        w_state_n   = IDLE;
        w_arp_gnt_n = 1'b0;
        w_udp_gnt_n = 1'b0;
        w_cnt_n     = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_arp_gnt  <= 1'b0;
      r_udp_gnt  <= 1'b0;
      r_cnt      <= '0;
      r_last_udp <= 1'b1;
      r_data     <= '0;
      r_data_vl  <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_arp_gnt  <= w_arp_gnt_n;
      r_udp_gnt  <= w_udp_gnt_n;
      r_cnt      <= w_cnt_n;
      r_last_udp <= w_last_udp_n;
      r_data     <= w_data_n;
      r_data_vl  <= w_data_vl_n;
      r_abort    <= w_abort_n;
    end
  end

  assign o_arp_gnt = r_arp_gnt;
  assign o_udp_gnt = r_udp_gnt;
  assign o_data    = r_data;
  assign o_data_vl = r_data_vl;
  assign o_busy    = (r_state != IDLE);
  assign o_abort   = r_abort;

endmodule

// File: doc/eth_tx_arb.md
ETH_TX_ARB -- requirements
Module: eth_tx_arb

Interface
REQ-001 Parameter IFG_CYCLES, default 12, inter-frame gap in clk cycles after each frame.
REQ-002 Parameter MAX_FRAME, default 1536, byte limit per frame before forced abort.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low, ports named clk and rst_n.
REQ-004 clk  input  1  system/PHY byte clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 i_arp_req  input  1  ARP-reply requester wants the TX stream.
REQ-007 i_arp_data / i_arp_data_vl / i_arp_last  input  8/1/1  ARP frame bytes, byte valid, last byte marker.
REQ-008 o_arp_gnt  output  1  ARP requester owns TX stream.
REQ-009 i_udp_req  input  1  UDP-send requester wants the TX stream.
REQ-010 i_udp_data / i_udp_data_vl / i_udp_last  input  8/1/1  UDP frame bytes, byte valid, last byte marker.
REQ-011 o_udp_gnt  output  1  UDP requester owns TX stream.
REQ-012 o_data / o_data_vl  output  8/1  byte stream to PHY TX.
REQ-013 o_busy  output  1  high in any state other than IDLE.
REQ-014 o_abort  output  1  one-cycle pulse when a frame is cut by MAX_FRAME.

Function
REQ-015 FSM states: IDLE, XFER, GAP; 2-bit encoding, IDLE=0.
REQ-016 IDLE: no request -> stay; any request -> XFER next cycle with exactly one grant asserted (registered).
REQ-017 Arbitration round-robin via 1-bit last_served pointer: both requesting -> grant the one not last served; single requester -> granted regardless.
REQ-018 last_served updates on entry to XFER to the granted requester; reset value UDP, so ARP wins the first contention.
REQ-019 XFER: o_data/o_data_vl = granted requester's data/vl registered, one-cycle latency; non-granted inputs ignored entirely.
REQ-020 Byte counter, 11 bits, cleared on XFER entry, +1 per granted vl byte.
REQ-021 Granted last with vl high -> GAP next cycle; that last byte still forwarded; grant drops the same edge.
REQ-022 last without vl ignored.
REQ-023 Counter reaching MAX_FRAME-1 with granted vl and no last -> byte forwarded, GAP next cycle, o_abort pulsed one cycle.
REQ-024 Requester deasserting req during XFER has no effect; frame ends only by REQ-021 or REQ-023.
REQ-025 GAP: o_data_vl low, counter of IFG_CYCLES cycles; at expiry -> IDLE; new grant no earlier than next cycle after IDLE entry.
REQ-026 Requests during GAP held off, arbitrated in IDLE per REQ-017.
REQ-027 Simultaneous last and MAX_FRAME limit on same byte -> normal end, no o_abort.
REQ-028 o_data holds last value when o_data_vl low; grants mutually exclusive at all times.

Reset
REQ-029 rst_n low asynchronously forces: state IDLE, grants 0, o_data 0, o_data_vl 0, o_busy 0, o_abort 0, counters 0, last_served UDP.
REQ-030 Reset mid-frame discards the frame; after release the FSM starts from IDLE with no residual output.

Verification
REQ-031 Only ARP requests, 42-byte frame, last on byte 42 -> o_arp_gnt cycle after req, 42 bytes out one-cycle delayed, then 12 idle cycles, o_busy low after.
REQ-032 ARP and UDP request same cycle from reset -> ARP granted first; UDP granted first IDLE cycle after ARP's 12-cycle gap.
REQ-033 Both continuously requesting, 3 frames each -> strict alternation ARP,UDP,ARP,UDP,ARP,UDP.
REQ-034 UDP frame with no last, vl every cycle, MAX_FRAME=1536 -> 1536 bytes forwarded, o_abort one pulse, GAP entered.
REQ-035 UDP data/vl toggling while ARP granted -> no UDP byte on o_data; valid gaps in ARP data produce matching o_data_vl gaps.
REQ-036 rst_n low at byte 20 of a frame -> all outputs 0 immediately; after release, pending request granted from IDLE normally.
